mips_cpu_pc_seq: RTL and testbench

MIPS_CPU_PC_SEQ -- requirements
Module: mips_cpu_pc_seq

---
 rtl/mips_cpu_pkg.sv | 23 ++
 rtl/mips_cpu_pc_target.sv | 35 +++
 rtl/mips_cpu_pc_seq.sv | 129 ++++++++++++
 tb/tb_mips_cpu_pc_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS fetch sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_cpu_pkg;

  // Fetch-control request presented alongside the current instruction.
  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_JR     = 2'd3
  } pc_ctrl_t;

  // Sequencer states; encoding 2'd3 is unused.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DELAY  = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;

endpackage

// File: rtl/mips_cpu_pc_target.sv
// Control-transfer target computation for branch, jump and jump-register.
// Latency: combinational, same cycle as ctrl.
// Backpressure: none; the result is consumed or ignored by the sequencer.
// Ports: pc (current fetch address), ctrl (transfer kind), imm (branch offset),
//        idx (jump index), reg_target (jump-register value), target (result).
module mips_cpu_pc_target
  import mips_cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  pc_ctrl_t    ctrl,
  input  logic [15:0] imm,
  input  logic [25:0] idx,
  input  logic [31:0] reg_target,
  output logic [31:0] target
);

  logic [31:0] pc_plus4;
  logic [31:0] br_offset;

  assign pc_plus4  = pc + 32'd4;
  // Word offset: sign-extend the 16-bit immediate and scale by 4.
  assign br_offset = {{14{imm[15]}}, imm, 2'b00};

  always_comb begin
    target = pc_plus4;
    case (ctrl)
      PC_BRANCH: target = pc_plus4 + br_offset;
      // Jump stays inside the 256 MB region of the delay-slot address.
      PC_JUMP:   target = {pc_plus4[31:28], idx, 2'b00};
      PC_JR:     target = reg_target;
      default:   target = pc_plus4;
    endcase
  end

endmodule

// File: rtl/mips_cpu_pc_seq.sv
// Program-counter sequencer with optional branch delay slot and halt detection.
// Latency: one cycle from pc_ctrl to pc_out update; link_addr is combinational.
// Backpressure: stall=1 freezes all state; pc_ctrl is ignored while stalled.
// Ports: clk, rst (sync, active-high), stall, pc_ctrl, instr, reg_readdata in;
//        pc_out, link_addr, in_delay_slot, active out; addr_err out only when
//        MIPS_CPU_PC_ALIGN_CHECK_EN is defined (misaligned jump-register check).
module mips_cpu_pc_seq
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = 32'h0000_0000,
  parameter int          DELAY_SLOT   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  pc_ctrl,
  input  logic [31:0] instr,
  input  logic [31:0] reg_readdata,
  output logic [31:0] pc_out,
  output logic [31:0] link_addr,
  output logic        in_delay_slot,
  output logic        active
`ifdef MIPS_CPU_PC_ALIGN_CHECK_EN
  ,
  output logic        addr_err
`endif
);

  pc_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        active_q, active_d;
  logic        err_q, err_d;
  pc_ctrl_t    ctrl;
  logic [31:0] target;
  logic        at_halt;
  logic        unused_instr_hi;

  assign ctrl            = pc_ctrl_t'(pc_ctrl);
  assign at_halt         = (pc_q == HALT_ADDR);
  assign unused_instr_hi = ^instr[31:26];

  mips_cpu_pc_target u_target (
    .pc         (pc_q),
    .ctrl       (ctrl),
    .imm        (instr[15:0]),
    .idx        (instr[25:0]),
    .reg_target (reg_readdata),
    .target     (target)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= RESET_VECTOR;
      pend_q   <= 32'd0;
      active_q <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    active_d = active_q;
    err_d    = err_q;
    if (!stall) begin
      case (state_q)
        RUN: begin
          // Halt outranks any control transfer requested in the same cycle.
          if (at_halt) begin
            state_d  = HALTED;
            active_d = 1'b0;
          end
`ifdef MIPS_CPU_PC_ALIGN_CHECK_EN
          else if (ctrl == PC_JR && reg_readdata[1:0] != 2'b00) begin
            state_d  = HALTED;
            active_d = 1'b0;
            err_d    = 1'b1;
          end
`endif
          else if (ctrl == PC_SEQ) begin
            pc_d = pc_q + 32'd4;
          end else if (DELAY_SLOT != 0) begin
            // Fetch the delay-slot instruction first; redirect on the next step.
            pend_d  = target;
            pc_d    = pc_q + 32'd4;
            state_d = DELAY;
          end else begin
            pc_d = target;
          end
        end
        DELAY: begin
          // A transfer requested by the delay-slot instruction is dropped.
          if (at_halt) begin
            state_d  = HALTED;
            active_d = 1'b0;
          end else begin
            pc_d    = pend_q;
            state_d = RUN;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign pc_out        = pc_q;
  assign link_addr     = pc_q + ((DELAY_SLOT != 0) ? 32'd8 : 32'd4);
  assign in_delay_slot = (state_q == DELAY);
  assign active        = active_q;
`ifdef MIPS_CPU_PC_ALIGN_CHECK_EN
  assign addr_err      = err_q;
`else
  logic unused_err;
  assign unused_err = err_q ^ (^err_d);
`endif

endmodule

// File: tb/tb_mips_cpu_pc_seq.sv
module tb_mips_cpu_pc_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: delay slot enabled. Instance B: immediate redirect.
  logic        rst_a = 1'b1, stall_a = 1'b0;
  logic [1:0]  ctrl_a = 2'd0;
  logic [31:0] instr_a = '0, rd_a = '0;
  logic [31:0] pc_a, link_a;
  logic        ds_a, act_a;
  logic        rst_b = 1'b1, stall_b = 1'b0;
  logic [1:0]  ctrl_b = 2'd0;
  logic [31:0] instr_b = '0, rd_b = '0;
  logic [31:0] pc_b, link_b;
  logic        ds_b, act_b;
`ifdef MIPS_CPU_PC_ALIGN_CHECK_EN
  logic        err_a, err_b;
`endif

  mips_cpu_pc_seq #(.DELAY_SLOT(1)) dut_a (
    .clk(clk), .rst(rst_a), .stall(stall_a), .pc_ctrl(ctrl_a),
    .instr(instr_a), .reg_readdata(rd_a), .pc_out(pc_a),
    .link_addr(link_a), .in_delay_slot(ds_a), .active(act_a)
`ifdef MIPS_CPU_PC_ALIGN_CHECK_EN
    , .addr_err(err_a)
`endif
  );

  mips_cpu_pc_seq #(.DELAY_SLOT(0)) dut_b (
    .clk(clk), .rst(rst_b), .stall(stall_b), .pc_ctrl(ctrl_b),
    .instr(instr_b), .reg_readdata(rd_b), .pc_out(pc_b),
    .link_addr(link_b), .in_delay_slot(ds_b), .active(act_b)
`ifdef MIPS_CPU_PC_ALIGN_CHECK_EN
    , .addr_err(err_b)
`endif
  );

  typedef struct {
    bit          sel;
    logic [31:0] pc;
    logic        ds;
    logic        act;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_empty observed=0 expected>0");
    end else begin
      e = sb.pop_front();
      if (!e.sel) begin
        cmp({e.tag, ".pc"},   pc_a,   e.pc);
        cmp({e.tag, ".link"}, link_a, e.pc + 32'd8);
        cmp({e.tag, ".ds"},   {31'd0, ds_a},  {31'd0, e.ds});
        cmp({e.tag, ".act"},  {31'd0, act_a}, {31'd0, e.act});
      end else begin
        cmp({e.tag, ".pc"},   pc_b,   e.pc);
        cmp({e.tag, ".link"}, link_b, e.pc + 32'd4);
        cmp({e.tag, ".ds"},   {31'd0, ds_b},  {31'd0, e.ds});
        cmp({e.tag, ".act"},  {31'd0, act_b}, {31'd0, e.act});
      end
    end
  endtask

  // Drive one cycle of stimulus into the selected instance, queue what it must
  // show after the next rising edge, then sample #1 after that edge.
  task automatic step(input bit sel, input logic r, input logic s, input logic [1:0] c,
                      input logic [31:0] ins, input logic [31:0] rd,
                      input logic [31:0] epc, input logic eds, input logic eact,
                      input string tag);
    exp_t e;
    if (!sel) begin
      rst_a = r; stall_a = s; ctrl_a = c; instr_a = ins; rd_a = rd;
    end else begin
      rst_b = r; stall_b = s; ctrl_b = c; instr_b = ins; rd_b = rd;
    end
    e.sel = sel; e.pc = epc; e.ds = eds; e.act = eact; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_front();
  endtask

  localparam logic [31:0] J100  = 32'h0800_0100; // jump index 0x100
  localparam logic [31:0] BRM2  = 32'h1000_FFFE; // branch offset -2 words
  localparam logic [31:0] BRP16 = 32'h1000_0010; // branch offset +16 words

  initial begin
    // Delay-slot build: reset and sequential fetch.
    step(0, 1, 0, 2'd0, 0, 0, 32'hBFC00000, 0, 1, "reset");
    step(0, 0, 0, 2'd0, 0, 0, 32'hBFC00004, 0, 1, "seq1");
    step(0, 0, 0, 2'd0, 0, 0, 32'hBFC00008, 0, 1, "seq2");
    step(0, 0, 0, 2'd0, 0, 0, 32'hBFC0000C, 0, 1, "seq3");
    step(0, 0, 0, 2'd0, 0, 0, 32'hBFC00010, 0, 1, "seq4");
    step(0, 0, 1, 2'd2, J100, 0, 32'hBFC00010, 0, 1, "stall_run");
    // Backward branch through a delay slot.
    step(0, 0, 0, 2'd1, BRM2, 0, 32'hBFC00014, 1, 1, "br_slot");
    step(0, 0, 0, 2'd0, 0, 0, 32'hBFC0000C, 0, 1, "br_back");
    // Jump, stall twice in the slot, then a dropped branch in the slot.
    step(0, 0, 0, 2'd2, J100, 0, 32'hBFC00010, 1, 1, "j_slot");
    step(0, 0, 1, 2'd3, 0, 32'h12345678, 32'hBFC00010, 1, 1, "stall_ds1");
    step(0, 0, 1, 2'd0, 0, 0, 32'hBFC00010, 1, 1, "stall_ds2");
    step(0, 0, 0, 2'd1, BRM2, 0, 32'hB0000400, 0, 1, "j_target");
    // Forward branch.
    step(0, 0, 0, 2'd1, BRP16, 0, 32'hB0000404, 1, 1, "brp_slot");
    step(0, 0, 0, 2'd0, 0, 0, 32'hB0000444, 0, 1, "brp_target");
    // Reset wins over stall; reset in the slot discards the pending target.
    step(0, 1, 1, 2'd3, 0, 32'h0, 32'hBFC00000, 0, 1, "rst_over_stall");
    step(0, 0, 0, 2'd2, J100, 0, 32'hBFC00004, 1, 1, "j2_slot");
    step(0, 1, 0, 2'd0, 0, 0, 32'hBFC00000, 0, 1, "rst_in_delay");
    step(0, 0, 0, 2'd0, 0, 0, 32'hBFC00004, 0, 1, "after_rst");
    // Jump-register to the halt address, halt beats a jump, then stays halted.
    step(0, 0, 0, 2'd3, 0, 32'h0, 32'hBFC00008, 1, 1, "jr_slot");
    step(0, 0, 0, 2'd0, 0, 0, 32'h00000000, 0, 1, "jr_target");
    step(0, 0, 0, 2'd2, J100, 0, 32'h00000000, 0, 0, "halt");
    for (int i = 0; i < 5; i++)
      step(0, 0, 0, 2'(i % 4), J100, 32'h40, 32'h00000000, 0, 0, "halted");
    step(0, 1, 0, 2'd0, 0, 0, 32'hBFC00000, 0, 1, "rst_from_halt");
    // Silent wrap from FFFFFFFC to 0, followed by halt.
    step(0, 0, 0, 2'd3, 0, 32'hFFFFFFF8, 32'hBFC00004, 1, 1, "wrap_slot");
    step(0, 0, 0, 2'd0, 0, 0, 32'hFFFFFFF8, 0, 1, "wrap_f8");
    step(0, 0, 0, 2'd0, 0, 0, 32'hFFFFFFFC, 0, 1, "wrap_fc");
    step(0, 0, 0, 2'd0, 0, 0, 32'h00000000, 0, 1, "wrap_zero");
    step(0, 0, 0, 2'd0, 0, 0, 32'h00000000, 0, 0, "wrap_halt");
    // Halt reached while the slot instruction sits at the halt address.
    step(0, 1, 0, 2'd0, 0, 0, 32'hBFC00000, 0, 1, "rst2");
    step(0, 0, 0, 2'd3, 0, 32'hFFFFFFFC, 32'hBFC00004, 1, 1, "jr_fc_slot");
    step(0, 0, 0, 2'd0, 0, 0, 32'hFFFFFFFC, 0, 1, "at_fc");
    step(0, 0, 0, 2'd2, J100, 0, 32'h00000000, 1, 1, "slot_at_zero");
    step(0, 0, 0, 2'd0, 0, 0, 32'h00000000, 0, 0, "halt_in_delay");
    // Misaligned jump-register.
    step(0, 1, 0, 2'd0, 0, 0, 32'hBFC00000, 0, 1, "rst3");
`ifdef MIPS_CPU_PC_ALIGN_CHECK_EN
    cmp("err_reset", {31'd0, err_a}, 32'd0);
    step(0, 0, 0, 2'd3, 0, 32'h00400002, 32'hBFC00000, 0, 0, "jr_misaligned");
    cmp("err_set", {31'd0, err_a}, 32'd1);
`else
    step(0, 0, 0, 2'd3, 0, 32'h00400002, 32'hBFC00004, 1, 1, "jr_odd_slot");
    step(0, 0, 0, 2'd0, 0, 0, 32'h00400002, 0, 1, "jr_odd_target");
`endif

    // Immediate-redirect build.
    step(1, 1, 0, 2'd0, 0, 0, 32'hBFC00000, 0, 1, "b_reset");
    step(1, 0, 0, 2'd2, J100, 0, 32'hB0000400, 0, 1, "b_jump");
    step(1, 0, 0, 2'd1, BRM2, 0, 32'hB00003FC, 0, 1, "b_branch");
    step(1, 0, 1, 2'd3, 0, 32'h0, 32'hB00003FC, 0, 1, "b_stall");
    step(1, 0, 0, 2'd0, 0, 0, 32'hB0000400, 0, 1, "b_seq");
    step(1, 0, 0, 2'd3, 0, 32'h0, 32'h00000000, 0, 1, "b_jr");
    step(1, 0, 0, 2'd1, BRP16, 0, 32'h00000000, 0, 0, "b_halt");

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
